mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle RISC-V core (port 0) and a program loader/debug master (port 1).
- Sits between the requesters and the memory, inside top.
- Arbitrates with round-robin or fixed priority plus a starvation guard, registers the winning transaction and drives exactly one memory access per grant.
- Returns an ack and read data.

Parameters:
- XLEN, 32, address/data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always preferred, subject to the starvation guard.
- STARVE_LIMIT, 4, in fixed mode, the number of consecutive lost arbitrations after which port 1 wins the next one. Range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- m0_req  in  1  port 0 request; hold until m0_ack.
- m0_we  in  1  port 0 write enable (1 = write).
- m0_adr  in  XLEN  port 0 byte address.
- m0_wd  in  XLEN  port 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rd  out  XLEN  read data, valid while m0_ack is high.
- m1_req, m1_we, m1_adr, m1_wd, m1_ack, m1_rd: identical to port 0, for port 1.
- mem_adr  out  XLEN  memory address (registered).
- mem_wd  out  XLEN  memory write data (registered).
- mem_we  out  1  memory write enable (registered).
- mem_rd  in  XLEN  memory combinational read data.
- busy  out  1  high in ACCESS or DONE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- On reset, immediately:
  - state = IDLE.
  - mem_we = 0, mem_adr = 0, mem_wd = 0.
  - m0_ack = m1_ack = 0, m0_rd = m1_rd = 0.
  - owner = 0, rr_last = 1 (port 0 favoured first), starve_cnt = 0, busy = 0.
- Requester contract:
  - Assert req with we/adr/wd stable until the ack cycle.
  - Deassert req in the ack cycle or the following one. req still high at the edge ending the DONE cycle is treated as a new request.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, no req: stay in IDLE; mem_we = 0.
- IDLE, any req, winner selection:
  - Single requester: it wins.
  - Both, FIXED_PRIO = 0: the port that is not rr_last wins.
  - Both, FIXED_PRIO = 1: port 0 wins unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
- IDLE, any req, at the edge:
  - Latch the winner's adr/wd/we into mem_adr/mem_wd/mem_we.
  - owner = winner, rr_last = winner, go to ACCESS.
- starve_cnt:
  - Increments when port 1 loses a both-requesting arbitration.
  - Clears when port 1 wins.
  - Saturates at STARVE_LIMIT.
  - Unused when FIXED_PRIO = 0 (held at 0).
- ACCESS (exactly one cycle):
  - mem_* are driven from the latched values; memory writes on the closing edge if mem_we = 1.
  - At that edge: capture mem_rd into the owner's rd register (for writes as well), set mem_we = 0, assert the owner's ack, go to DONE.
- DONE (one cycle): owner's ack = 1, rd valid. At the edge: ack = 0, go to IDLE.
- Latency and throughput:
  - Request sampled at edge E.
  - Access cycle is E..E+1.
  - Ack high during E+1..E+2.
  - Maximum one transaction per 3 cycles.
- Persistence: rd registers hold their value after ack until overwritten. The non-owner's ack and rd are untouched.
- Request timing: a request arriving during ACCESS or DONE waits; it is sampled in the next IDLE cycle.
- Reset mid-operation (ACCESS or DONE):
  - Immediate return to the reset values.
  - A write whose closing edge has not occurred is dropped, because mem_we is forced to 0 asynchronously.
  - No ack is issued for the aborted transaction.
- Addresses and data pass through unmodified (no alignment checks; full XLEN).

Test Plan:
- Single write: m0 only; m0_we = 1, m0_adr = 0x64, m0_wd = 0x19 -> one ACCESS cycle with mem_adr = 0x64, mem_wd = 0x19, mem_we = 1 for exactly 1 cycle; m0_ack pulses 1 cycle, 2 cycles after sampling; m1_ack stays 0.
- Single read: m1 reads 0x20 with memory returning 0xDEADBEEF -> mem_we = 0 throughout; m1_rd = 0xDEADBEEF during m1_ack; m0_rd stays 0.
- Round-robin (FIXED_PRIO = 0): both ports request continuously from reset -> grant order m0, m1, m0, m1; each ack 3 cycles apart; each requester re-asserts after its ack.
- Fixed priority with starvation (FIXED_PRIO = 1, STARVE_LIMIT = 3): both ports request continuously -> grants m0, m0, m0, m1, m0, m0, m0, m1; starve_cnt clears after each m1 grant.
- Reset during ACCESS: m0 write of 0x55 to 0x10; reset asserted mid-ACCESS before the closing edge -> mem_we drops to 0 immediately, memory[0x10] unchanged, no m0_ack; after release, state = IDLE and busy = 0.
- Back-to-back and late request: m1_req rises during m0's DONE cycle -> m1 is not granted until the following IDLE cycle, then completes normally; m0 keeping req high through DONE results in a second m0 transaction only if m1 is not requesting (round-robin mode).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared instruction/data memory port.
// Picks a winner (round-robin or fixed priority with starvation guard) and runs one memory access per grant.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter bit FIXED_PRIO   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [XLEN-1:0] m0_adr,
    input  logic [XLEN-1:0] m0_wd,
    output logic            m0_ack,
    output logic [XLEN-1:0] m0_rd,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [XLEN-1:0] m1_adr,
    input  logic [XLEN-1:0] m1_wd,
    output logic            m1_ack,
    output logic [XLEN-1:0] m1_rd,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_wd,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rd,
    output logic            busy
);

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t          state_r, state_nxt_s;
    logic            owner_r, owner_nxt_s;
    logic            rr_last_r, rr_last_nxt_s;
    logic [3:0]      starve_cnt_r, starve_cnt_nxt_s;
    logic [XLEN-1:0] mem_adr_nxt_s, mem_wd_nxt_s, m0_rd_nxt_s, m1_rd_nxt_s;
    logic            mem_we_nxt_s, m0_ack_nxt_s, m1_ack_nxt_s, busy_nxt_s;
    logic            any_req_s, both_req_s, win_s;

    assign any_req_s  = m0_req | m1_req;
    assign both_req_s = m0_req & m1_req;

    // Winner selection; only meaningful in IDLE.
    always_comb begin
        win_s = 1'b0;
        if (both_req_s) begin
            if (FIXED_PRIO) begin
                win_s = (starve_cnt_r == LIMIT);
            end else begin
                win_s = ~rr_last_r;
            end
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE:    state_nxt_s = any_req_s ? ACCESS : IDLE;
            ACCESS:  state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/datapath next values; acks default low so they pulse for exactly one cycle.
    always_comb begin
        mem_adr_nxt_s    = mem_adr;
        mem_wd_nxt_s     = mem_wd;
        mem_we_nxt_s     = 1'b0;
        m0_rd_nxt_s      = m0_rd;
        m1_rd_nxt_s      = m1_rd;
        m0_ack_nxt_s     = 1'b0;
        m1_ack_nxt_s     = 1'b0;
        owner_nxt_s      = owner_r;
        rr_last_nxt_s    = rr_last_r;
        starve_cnt_nxt_s = starve_cnt_r;
        busy_nxt_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    mem_adr_nxt_s = win_s ? m1_adr : m0_adr;
                    mem_wd_nxt_s  = win_s ? m1_wd  : m0_wd;
                    mem_we_nxt_s  = win_s ? m1_we  : m0_we;
                    owner_nxt_s   = win_s;
                    rr_last_nxt_s = win_s;
                    busy_nxt_s    = 1'b1;
                    if (!FIXED_PRIO) begin
                        starve_cnt_nxt_s = 4'd0;
                    end else if (win_s) begin
                        starve_cnt_nxt_s = 4'd0;
                    end else if (both_req_s && (starve_cnt_r != LIMIT)) begin
                        starve_cnt_nxt_s = starve_cnt_r + 4'd1;
                    end else begin
                        starve_cnt_nxt_s = starve_cnt_r;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ACCESS: begin
                busy_nxt_s = 1'b1;
                if (owner_r) begin
                    m1_rd_nxt_s  = mem_rd;
                    m1_ack_nxt_s = 1'b1;
                end else begin
                    m0_rd_nxt_s  = mem_rd;
                    m0_ack_nxt_s = 1'b1;
                end
            end
            DONE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset also kills an in-flight write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_adr    <= {XLEN{1'b0}};
            mem_wd     <= {XLEN{1'b0}};
            mem_we     <= 1'b0;
            m0_rd      <= {XLEN{1'b0}};
            m1_rd      <= {XLEN{1'b0}};
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            owner_r    <= 1'b0;
            rr_last_r  <= 1'b1;
            starve_cnt_r <= 4'd0;
            busy       <= 1'b0;
        end else begin
            mem_adr    <= mem_adr_nxt_s;
            mem_wd     <= mem_wd_nxt_s;
            mem_we     <= mem_we_nxt_s;
            m0_rd      <= m0_rd_nxt_s;
            m1_rd      <= m1_rd_nxt_s;
            m0_ack     <= m0_ack_nxt_s;
            m1_ack     <= m1_ack_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_last_r  <= rr_last_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            busy       <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with a word memory model
// and a fixed-priority instance (STARVE_LIMIT = 3) sharing the same requester inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr = 32'h0, m0_wd = 32'h0, m1_adr = 32'h0, m1_wd = 32'h0;

    logic        m0_ack, m1_ack, mem_we, busy;
    logic [31:0] m0_rd, m1_rd, mem_adr, mem_wd, mem_rd;
    logic        b_m0_ack, b_m1_ack, b_mem_we, b_busy;
    logic [31:0] b_m0_rd, b_m1_rd, b_mem_adr, b_mem_wd;
    logic [31:0] b_mem_rd = 32'h0000_0000;

    logic [31:0] mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_adr[9:2]];

    mem_port_arbiter #(.XLEN(32), .FIXED_PRIO(1'b0), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
    );

    mem_port_arbiter #(.XLEN(32), .FIXED_PRIO(1'b1), .STARVE_LIMIT(3)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd), .m0_ack(b_m0_ack), .m0_rd(b_m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd), .m1_ack(b_m1_ack), .m1_rd(b_m1_rd),
        .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(b_mem_rd), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_adr = 32'h0; m0_wd = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = 32'h0; m1_wd = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %h exp 0", mem_we); end
        vectors++; if (mem_adr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_adr got %h exp 0", mem_adr); end
        vectors++; if (mem_wd !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wd got %h exp 0", mem_wd); end
        vectors++; if ({m0_ack, m1_ack} !== 2'b00) begin miscompares++; $display("FAIL rst_acks got %b exp 00", {m0_ack, m1_ack}); end
        vectors++; if (m0_rd !== 32'h0 || m1_rd !== 32'h0) begin miscompares++; $display("FAIL rst_rd got %h/%h exp 0/0", m0_rd, m1_rd); end
        vectors++; if (busy !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b/%b exp 0/0", busy, b_busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single_write();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h64; m0_wd = 32'h19;
        tick();
        vectors++; if ({mem_adr, mem_wd, mem_we} !== {32'h64, 32'h19, 1'b1}) begin miscompares++; $display("FAIL wr_access got adr %h wd %h we %b exp 64 19 1", mem_adr, mem_wd, mem_we); end
        vectors++; if ({busy, m0_ack} !== 2'b10) begin miscompares++; $display("FAIL wr_access_busy_ack got %b exp 10", {busy, m0_ack}); end
        tick();
        vectors++; if ({m0_ack, m1_ack, mem_we, busy} !== 4'b1001) begin miscompares++; $display("FAIL wr_done got ack0 ack1 we busy %b exp 1001", {m0_ack, m1_ack, mem_we, busy}); end
        vectors++; if (m0_rd !== 32'h1000_0019) begin miscompares++; $display("FAIL wr_rd_capture got %h exp 10000019", m0_rd); end
        m0_req = 1'b0;
        tick();
        vectors++; if ({m0_ack, m1_ack, mem_we, busy} !== 4'b0000) begin miscompares++; $display("FAIL wr_after got %b exp 0000", {m0_ack, m1_ack, mem_we, busy}); end
        vectors++; if (mem[25] !== 32'h19) begin miscompares++; $display("FAIL wr_memory got %h exp 19", mem[25]); end
    endtask

    task automatic test_single_read();
        mem[8] <= 32'hDEAD_BEEF;
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h20;
        tick();
        vectors++; if ({mem_adr, mem_we, busy} !== {32'h20, 1'b0, 1'b1}) begin miscompares++; $display("FAIL rd_access got adr %h we %b busy %b exp 20 0 1", mem_adr, mem_we, busy); end
        tick();
        vectors++; if ({m1_ack, m0_ack, mem_we} !== 3'b100) begin miscompares++; $display("FAIL rd_done got %b exp 100", {m1_ack, m0_ack, mem_we}); end
        vectors++; if (m1_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data got %h exp deadbeef", m1_rd); end
        vectors++; if (m0_rd !== 32'h0) begin miscompares++; $display("FAIL rd_other_rd got %h exp 0", m0_rd); end
        m1_req = 1'b0;
        tick();
        vectors++; if ({m1_ack, busy} !== 2'b00 || m1_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_hold got ack %b busy %b rd %h exp 0 0 deadbeef", m1_ack, busy, m1_rd); end
    endtask

    task automatic test_round_robin();
        logic e0, e1;
        do_reset();
        m0_req = 1'b1; m0_adr = 32'h04; m1_req = 1'b1; m1_adr = 32'h08;
        for (int c = 1; c <= 12; c++) begin
            tick();
            e0 = (c == 2) || (c == 8);
            e1 = (c == 5) || (c == 11);
            vectors++; if ({m0_ack, m1_ack} !== {e0, e1}) begin miscompares++; $display("FAIL rr_cycle%0d got acks %b exp %b", c, {m0_ack, m1_ack}, {e0, e1}); end
            if (c == 5) begin
                vectors++; if (m0_rd !== 32'h1000_0001 || m1_rd !== 32'h1000_0002) begin miscompares++; $display("FAIL rr_rd got %h/%h exp 10000001/10000002", m0_rd, m1_rd); end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_fixed_starve();
        logic [7:0] m1_grant;
        logic e0, e1;
        m1_grant = 8'b1000_1000;
        do_reset();
        m0_req = 1'b1; m0_adr = 32'h04; m1_req = 1'b1; m1_adr = 32'h08;
        for (int c = 1; c <= 24; c++) begin
            tick();
            e1 = ((c % 3) == 2) && m1_grant[(c - 2) / 3];
            e0 = ((c % 3) == 2) && !m1_grant[(c - 2) / 3];
            vectors++; if ({b_m0_ack, b_m1_ack} !== {e0, e1}) begin miscompares++; $display("FAIL fixed_cycle%0d got acks %b exp %b", c, {b_m0_ack, b_m1_ack}, {e0, e1}); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_reset_access();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h10; m0_wd = 32'h55;
        tick();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL abort_pre_we got %b exp 1", mem_we); end
        #3;
        reset = 1'b1;
        #1;
        vectors++; if ({mem_we, busy} !== 2'b00 || mem_adr !== 32'h0) begin miscompares++; $display("FAIL abort_async got we %b busy %b adr %h exp 0 0 0", mem_we, busy, mem_adr); end
        tick();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL abort_ack got %b exp 0", m0_ack); end
        reset = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
        tick();
        vectors++; if ({busy, m0_ack, mem_we} !== 3'b000) begin miscompares++; $display("FAIL abort_after got %b exp 000", {busy, m0_ack, mem_we}); end
        vectors++; if (mem[4] !== 32'h1000_0004) begin miscompares++; $display("FAIL abort_memory got %h exp 10000004", mem[4]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h0C;
        tick();
        tick();
        vectors++; if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_m0_ack got %b exp 1", m0_ack); end
        m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h14;
        tick();
        vectors++; if ({busy, m1_ack} !== 2'b00) begin miscompares++; $display("FAIL b2b_late_idle got busy/ack %b exp 00", {busy, m1_ack}); end
        tick();
        vectors++; if (busy !== 1'b1 || mem_adr !== 32'h14) begin miscompares++; $display("FAIL b2b_m1_grant got busy %b adr %h exp 1 14", busy, mem_adr); end
        tick();
        vectors++; if ({m1_ack, m0_ack} !== 2'b10 || m1_rd !== 32'h1000_0005) begin miscompares++; $display("FAIL b2b_m1_done got acks %b rd %h exp 10 10000005", {m1_ack, m0_ack}, m1_rd); end
        m1_req = 1'b0;
        tick();
        m0_req = 1'b1;
        tick();
        tick();
        vectors++; if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_m0_first got %b exp 1", m0_ack); end
        tick();
        vectors++; if ({busy, m0_ack} !== 2'b00) begin miscompares++; $display("FAIL b2b_m0_gap got %b exp 00", {busy, m0_ack}); end
        tick();
        vectors++; if (busy !== 1'b1 || mem_adr !== 32'h0C) begin miscompares++; $display("FAIL b2b_m0_regrant got busy %b adr %h exp 1 0c", busy, mem_adr); end
        tick();
        vectors++; if ({m0_ack, m1_ack} !== 2'b10) begin miscompares++; $display("FAIL b2b_m0_second got %b exp 10", {m0_ack, m1_ack}); end
        m0_req = 1'b0;
        tick();
        vectors++; if ({busy, m0_ack} !== 2'b00) begin miscompares++; $display("FAIL b2b_end got %b exp 00", {busy, m0_ack}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
        tick();
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_fixed_starve();
        test_reset_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
